// File: rtl/pipeline_controller_pkg.sv
// Shared processor package: pipeline-controller state encoding and
// performance-counter width.
package pipeline_controller_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      REDIRECT = 2'b10
   } state_t;

   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
import pipeline_controller_pkg::*;

module sat_counter #(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Clear wins over increment; increment stops at the top value.
   always_ff @(posedge clk) begin
      if (reset || clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard/flow controller: memory-wait freeze, taken-branch
// redirect, load-use bubble, plus stall/flush performance counters.
import pipeline_controller_pkg::*;

module pipeline_controller (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             PC_EN,
   output logic             PC_SEL,
   output logic             IFID_EN,
   output logic             IFID_FLUSH,
   output logic             IDEX_EN,
   output logic             IDEX_FLUSH,
   output logic             EXMEM_EN,
   output logic             MEMWB_FLUSH,
   output logic [1:0]       STATE,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   state_t state_q;
   state_t state_d;
   logic   mem_wait;
   logic   load_use;
   logic   stall_inc;
   logic   flush_inc;

   // Hazard detection: data-memory freeze and load-use on a real register.
   always_comb begin
      mem_wait = mem_req && !mem_ready;
      load_use = ex_memread && (ex_rd != '0) &&
                 (((ex_rd == id_rs1) && id_use_rs1) ||
                  ((ex_rd == id_rs2) && id_use_rs2));
   end

   // Control outputs and next state; priority is reset > memory wait >
   // taken branch > per-state behaviour (redirect flush or load-use bubble).
   always_comb begin
      PC_EN       = 1'b1;
      PC_SEL      = 1'b0;
      IFID_EN     = 1'b1;
      IFID_FLUSH  = 1'b0;
      IDEX_EN     = 1'b1;
      IDEX_FLUSH  = 1'b0;
      EXMEM_EN    = 1'b1;
      MEMWB_FLUSH = 1'b0;
      state_d     = RUN;
      if (reset) begin
         PC_EN       = 1'b0;
         IFID_EN     = 1'b0;
         IDEX_EN     = 1'b0;
         EXMEM_EN    = 1'b0;
         IFID_FLUSH  = 1'b1;
         IDEX_FLUSH  = 1'b1;
         MEMWB_FLUSH = 1'b1;
      end else if (mem_wait) begin
         PC_EN       = 1'b0;
         IFID_EN     = 1'b0;
         IDEX_EN     = 1'b0;
         EXMEM_EN    = 1'b0;
         MEMWB_FLUSH = 1'b1;
         state_d     = MEM_WAIT;
      end else if (ex_branch_taken) begin
         PC_SEL      = 1'b1;
         IFID_FLUSH  = 1'b1;
         IDEX_FLUSH  = 1'b1;
         state_d     = REDIRECT;
      end else begin
         case (state_q)
            RUN: begin
               if (load_use) begin
                  PC_EN      = 1'b0;
                  IFID_EN    = 1'b0;
                  IDEX_FLUSH = 1'b1;
               end
            end
            // Second wrong-path fetch arrives one cycle late (registered imem).
            REDIRECT: IFID_FLUSH = 1'b1;
            default: ;
         endcase
      end
   end

   // State register; the unused 2'b11 encoding falls back to RUN via state_d.
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= RUN;
      else
         state_q <= state_d;
   end

   // Counter increment conditions; reset-forced PC_EN=0 is not a stall.
   always_comb begin
      stall_inc = !reset && !PC_EN;
      flush_inc = PC_SEL;
   end

   assign STATE = state_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (perf_clr),
      .inc   (stall_inc),
      .count (STALL_CNT)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (perf_clr),
      .inc   (flush_inc),
      .count (FLUSH_CNT)
   );

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model built from the event history.
module tb_pipeline_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_memread;
   logic [4:0]  ex_rd, id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2;
   logic        ex_branch_taken;
   logic        mem_req, mem_ready;
   logic        perf_clr;
   logic        PC_EN, PC_SEL, IFID_EN, IFID_FLUSH;
   logic        IDEX_EN, IDEX_FLUSH, EXMEM_EN, MEMWB_FLUSH;
   logic [1:0]  STATE;
   logic [15:0] STALL_CNT, FLUSH_CNT;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_controller dut (
      .clk             (clk),
      .reset           (reset),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_use_rs1      (id_use_rs1),
      .id_use_rs2      (id_use_rs2),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .perf_clr        (perf_clr),
      .PC_EN           (PC_EN),
      .PC_SEL          (PC_SEL),
      .IFID_EN         (IFID_EN),
      .IFID_FLUSH      (IFID_FLUSH),
      .IDEX_EN         (IDEX_EN),
      .IDEX_FLUSH      (IDEX_FLUSH),
      .EXMEM_EN        (EXMEM_EN),
      .MEMWB_FLUSH     (MEMWB_FLUSH),
      .STATE           (STATE),
      .STALL_CNT       (STALL_CNT),
      .FLUSH_CNT       (FLUSH_CNT)
   );

   // Control vector order: PC_EN PC_SEL IFID_EN IFID_FLUSH IDEX_EN IDEX_FLUSH EXMEM_EN MEMWB_FLUSH
   localparam logic [7:0] C_RESET  = 8'b0001_0101;
   localparam logic [7:0] C_DEF    = 8'b1010_1010;
   localparam logic [7:0] C_FREEZE = 8'b0000_0001;
   localparam logic [7:0] C_BRANCH = 8'b1111_1110;
   localparam logic [7:0] C_REDIR  = 8'b1011_1010;
   localparam logic [7:0] C_BUBBLE = 8'b0000_1110;

   function automatic logic [7:0] ctrl_now();
      return {PC_EN, PC_SEL, IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN, MEMWB_FLUSH};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // What happened last cycle: 0 = nothing special, 1 = memory freeze, 2 = branch redirect.
   int last_ev = 0;
   int m_stall = 0;
   int m_flush = 0;

   function automatic logic [7:0] model_ctrl(input int ev);
      logic w, lu;
      w  = mem_req && !mem_ready;
      lu = ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
      if (reset)           return C_RESET;
      if (w)               return C_FREEZE;
      if (ex_branch_taken) return C_BRANCH;
      if (ev == 2)         return C_REDIR;
      if (ev == 0 && lu)   return C_BUBBLE;
      return C_DEF;
   endfunction

   // Per-cycle compare against the model, then advance the model to the next edge.
   initial begin
      logic [7:0] exp_c;
      logic [1:0] exp_s;
      @(posedge clk);
      forever begin
         @(negedge clk);
         exp_c = model_ctrl(last_ev);
         exp_s = (last_ev == 1) ? 2'b01 : (last_ev == 2) ? 2'b10 : 2'b00;
         chk("model_ctrl", {24'd0, ctrl_now()}, {24'd0, exp_c});
         chk("model_state", {30'd0, STATE}, {30'd0, exp_s});
         chk("model_stall_cnt", {16'd0, STALL_CNT}, m_stall);
         chk("model_flush_cnt", {16'd0, FLUSH_CNT}, m_flush);
         if (reset) begin
            last_ev = 0;
            m_stall = 0;
            m_flush = 0;
         end else begin
            last_ev = (mem_req && !mem_ready) ? 1 : ex_branch_taken ? 2 : 0;
            if (perf_clr) begin
               m_stall = 0;
               m_flush = 0;
            end else begin
               if (!exp_c[7] && m_stall < 65535) m_stall++;
               if (exp_c[6]  && m_flush < 65535) m_flush++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      ex_memread = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; ex_branch_taken = 0;
      mem_req = 0; mem_ready = 0; perf_clr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_use_in();
      ex_memread = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1;
   endtask

   initial begin
      idle();
      reset = 1;
      // Reset-value outputs
      repeat (2) begin
         step();
         #1 chk("reset_ctrl", {24'd0, ctrl_now()}, {24'd0, C_RESET});
      end
      step(); reset = 0; idle();
      #1;
      chk("post_reset_state", {30'd0, STATE}, 0);
      chk("post_reset_stall", {16'd0, STALL_CNT}, 0);
      chk("post_reset_ctrl", {24'd0, ctrl_now()}, {24'd0, C_DEF});

      // Load-use bubble
      step(); load_use_in();
      #1 chk("lu_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b0000_1110});
      step(); idle();
      #1;
      chk("lu_stall_cnt", {16'd0, STALL_CNT}, 1);
      chk("lu_state", {30'd0, STATE}, 0);

      // x0 destination never stalls
      step(); load_use_in(); ex_rd = 0; id_rs1 = 0;
      #1 chk("x0_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b1010_1010});
      step(); idle();
      #1 chk("x0_stall_cnt", {16'd0, STALL_CNT}, 1);

      // Taken branch
      step(); ex_branch_taken = 1;
      #1 chk("br_c0_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b1111_1110});
      step(); idle();
      #1;
      chk("br_c1_state", {30'd0, STATE}, 2);
      chk("br_c1_ifid_flush", {31'd0, IFID_FLUSH}, 1);
      chk("br_c1_pc_sel", {31'd0, PC_SEL}, 0);
      step();
      #1;
      chk("br_c2_state", {30'd0, STATE}, 0);
      chk("br_flush_cnt", {16'd0, FLUSH_CNT}, 1);

      // Memory wait with branch held in EX
      for (int i = 0; i < 3; i++) begin
         step(); mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
         #1 chk("mw_freeze_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b0000_0001});
         if (i > 0) chk("mw_state", {30'd0, STATE}, 1);
      end
      step(); mem_ready = 1;
      #1;
      chk("mw_release_pc_sel", {31'd0, PC_SEL}, 1);
      chk("mw_release_state", {30'd0, STATE}, 1);
      chk("mw_stall_cnt", {16'd0, STALL_CNT}, 4);
      step(); idle();
      #1;
      chk("mw_redirect_state", {30'd0, STATE}, 2);
      chk("mw_flush_cnt", {16'd0, FLUSH_CNT}, 2);
      step();

      // Reset in the middle of a memory wait
      step(); mem_req = 1; mem_ready = 0;
      step(); reset = 1; ex_branch_taken = 1; load_use_in();
      #1;
      chk("rst_mw_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b0001_0101});
      chk("rst_mw_state_before_edge", {30'd0, STATE}, 1);
      step();
      #1;
      chk("rst_mw_ctrl_held", {24'd0, ctrl_now()}, {24'd0, 8'b0001_0101});
      chk("rst_mw_state", {30'd0, STATE}, 0);
      chk("rst_mw_counts", {STALL_CNT, FLUSH_CNT}, 0);
      step(); reset = 0; idle();
      #1;
      chk("rst_rel_ctrl", {24'd0, ctrl_now()}, {24'd0, 8'b1010_1010});
      step();
      #1;
      chk("rst_rel_state", {30'd0, STATE}, 0);
      chk("rst_rel_pc_sel", {31'd0, PC_SEL}, 0);

      // Randomized traffic, small register range so hazards are frequent
      repeat (4000) begin
         step();
         reset           = ($urandom_range(0, 99) == 0);
         perf_clr        = ($urandom_range(0, 49) == 0);
         ex_memread      = $urandom_range(0, 1);
         ex_rd           = 5'($urandom_range(0, 3));
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_use_rs1      = $urandom_range(0, 1);
         id_use_rs2      = $urandom_range(0, 1);
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         mem_req         = ($urandom_range(0, 2) == 0);
         mem_ready       = $urandom_range(0, 1);
      end

      // Saturation and clear of the stall counter
      step(); idle(); reset = 1;
      step(); reset = 0;
      repeat (65534) begin
         step(); mem_req = 1; mem_ready = 0;
      end
      step(); idle();
      #1 chk("sat_preload", {16'd0, STALL_CNT}, 32'hFFFE);
      repeat (3) begin
         step(); idle(); load_use_in();
      end
      step(); idle();
      #1 chk("sat_hold", {16'd0, STALL_CNT}, 32'hFFFF);
      step(); load_use_in(); perf_clr = 1;
      #1 chk("clr_stall_pc_en", {31'd0, PC_EN}, 0);
      step(); idle();
      #1 chk("clr_overrides_inc", {16'd0, STALL_CNT}, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have inputs ex_memread (1), the load flag carried in ID/EX, and ex_rd (5), the destination register in EX.
REQ-004 SHALL have inputs id_rs1 and id_rs2 (5 each), and id_use_rs1 and id_use_rs2 (1 each), for the source registers of the instruction in ID.
REQ-005 SHALL have input ex_branch_taken (1), asserted when the EX-stage branch or jump resolves taken.
REQ-006 SHALL have inputs mem_req (1), data-memory access in MEM, and mem_ready (1), data memory completes this cycle.
REQ-007 SHALL have input perf_clr (1), which clears the counters.
REQ-008 SHALL have pipeline-control outputs, 1 bit each: PC_EN, PC_SEL (1 = branch target), IFID_EN, IFID_FLUSH, IDEX_EN, IDEX_FLUSH, EXMEM_EN and MEMWB_FLUSH.
REQ-009 SHALL have output STATE (2), the current FSM state.
REQ-010 SHALL have outputs STALL_CNT and FLUSH_CNT (16 each), saturating performance counters.

Function
REQ-011 SHALL implement FSM states RUN=2'b00, MEM_WAIT=2'b01 and REDIRECT=2'b10; encoding 2'b11 SHALL return to RUN on the next edge.
REQ-012 SHALL use default outputs in RUN, REDIRECT and MEM_WAIT of: all *_EN=1, all *_FLUSH=0, PC_SEL=0.
REQ-013 SHALL detect a memory wait in any state when mem_req and !mem_ready:
- PC_EN, IFID_EN, IDEX_EN and EXMEM_EN all 0, and MEMWB_FLUSH=1, in the same cycle.
- Next state is MEM_WAIT.
REQ-014 SHALL remain in MEM_WAIT while mem_req and !mem_ready, and leave MEM_WAIT the cycle mem_ready=1:
- Outputs are the defaults.
- Next state is RUN, or REDIRECT if ex_branch_taken is set in that cycle (see REQ-015).
REQ-015 SHALL handle a taken branch when no memory wait is active and ex_branch_taken=1:
- PC_SEL=1, IFID_FLUSH=1, IDEX_FLUSH=1 in the same cycle.
- Next state is REDIRECT.
REQ-016 SHALL, in REDIRECT, assert IFID_FLUSH=1 for exactly one cycle to cancel the second wrong-path fetch (instruction memory read is registered), then return to RUN.
REQ-017 SHALL detect a load-use hazard in RUN when ex_memread and ex_rd!=0 and ((ex_rd==id_rs1 and id_use_rs1) or (ex_rd==id_rs2 and id_use_rs2)):
- PC_EN=0, IFID_EN=0, IDEX_FLUSH=1 for one cycle.
- State stays RUN; no added latency beyond one bubble.
REQ-018 SHALL apply this priority in a single cycle: memory wait > taken branch > load-use.
- A branch held in EX during a freeze SHALL be acted on in the cycle mem_ready=1.
- Load-use SHALL be ignored in REDIRECT and whenever a branch is taken.
REQ-019 SHALL produce all control outputs combinationally from state and inputs, with zero-cycle latency.
REQ-020 SHALL increment STALL_CNT by 1 in each cycle PC_EN=0 from REQ-013 or REQ-017.
REQ-021 SHALL increment FLUSH_CNT by 1 in each cycle PC_SEL=1.
REQ-022 SHALL hold both counters at 16'hFFFF once reached (no wrap).
REQ-023 SHALL clear both counters to 0 on perf_clr; perf_clr overrides a simultaneous increment.

Reset
REQ-024 SHALL, on the edge where reset=1, set STATE=RUN and STALL_CNT=FLUSH_CNT=0.
REQ-025 SHALL, while reset=1, hold PC_EN=IFID_EN=IDEX_EN=EXMEM_EN=0, IFID_FLUSH=IDEX_FLUSH=MEMWB_FLUSH=1 and PC_SEL=0, regardless of other inputs.
REQ-026 SHALL, on reset asserted mid-MEM_WAIT or mid-REDIRECT, abandon the operation with no pending redirect retained, and come out of reset in RUN with default outputs.

Structure
REQ-027 SHALL place the state encoding constants (RUN, MEM_WAIT, REDIRECT) and the counter width constant (16) in the shared processor package.
REQ-028 SHALL implement the saturating counter as one sub-module, sat_counter (inputs: clk, reset, clr, inc; output: count), instantiated twice.
REQ-029 SHALL keep the hazard comparator inline.

Verification
REQ-030 SHALL verify load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 in RUN -> PC_EN=0, IFID_EN=0, IDEX_FLUSH=1 for 1 cycle; STALL_CNT 0->1; STATE stays 00.
REQ-031 SHALL verify the x0 exemption: same as REQ-030 but ex_rd=0 -> no stall, outputs default, STALL_CNT unchanged.
REQ-032 SHALL verify a taken branch: ex_branch_taken=1 in RUN -> cycle 0: PC_SEL=1, IFID_FLUSH=1, IDEX_FLUSH=1; cycle 1: STATE=10, IFID_FLUSH=1; cycle 2: STATE=00; FLUSH_CNT=1.
REQ-033 SHALL verify a memory wait with a pending branch: mem_req=1, mem_ready=0 for 3 cycles with ex_branch_taken=1 throughout -> 3 frozen cycles, MEMWB_FLUSH=1, STALL_CNT=3; then mem_ready=1 -> PC_SEL=1 in that cycle; next cycle STATE=10.
REQ-034 SHALL verify saturation and clear: preload STALL_CNT to 16'hFFFE, apply 3 load-use stalls -> STALL_CNT=16'hFFFF; perf_clr=1 together with a stall -> STALL_CNT=0.
REQ-035 SHALL verify reset mid-wait: reset=1 during MEM_WAIT -> reset-value outputs while reset=1; after reset release, STATE=00, counters 0, and no PC_SEL pulse.
